word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning input word width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning input words per output beat; legal range 2..16.
REQ-003 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid input 1: upstream word valid.
REQ-006 SHALL have port s_ready output 1: block accepts word this cycle.
REQ-007 SHALL have port s_data input WORD_WIDTH: upstream word.
REQ-008 SHALL have port s_last input 1: word ends a packet; forces flush of partial beat.
REQ-009 SHALL have port m_valid output 1: packed beat valid.
REQ-010 SHALL have port m_ready input 1: downstream accepts beat.
REQ-011 SHALL have port m_data output WORD_WIDTH*RATIO: packed beat, lane i = bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-012 SHALL have port m_keep output RATIO: bit i set when lane i carries a valid word.
REQ-013 SHALL have port m_last output 1: beat closes a packet.
REQ-014 SHALL have port beat_count output 16: count of beats accepted downstream, wraps 0xFFFF->0x0000.

Function
REQ-015 Word transfer SHALL occur when s_valid && s_ready; beat transfer when m_valid && m_ready.
REQ-016 s_ready SHALL equal !rst && (!m_valid || m_ready); the only combinational input-to-output path is m_ready->s_ready.
REQ-017 Lane counter cnt (width $clog2(RATIO)) SHALL point at next lane to fill; first word of a beat goes to lane 0 (LSB).
REQ-018 On word transfer with cnt < RATIO-1 and s_last=0: word SHALL be stored in lane cnt of assembly register, cnt increments, outputs unchanged except as per REQ-021.
REQ-019 On word transfer with cnt == RATIO-1 or s_last=1 (completion): next cycle m_data = assembly lanes 0..cnt-1 plus s_data in lane cnt, lanes above cnt zero; m_keep = lanes 0..cnt set; m_last = s_last; m_valid = 1; cnt = 0; assembly register cleared.
REQ-020 Latency SHALL be one cycle from completing word transfer to m_valid high.
REQ-021 On beat transfer with no completion in the same cycle: m_valid SHALL drop to 0 next cycle; m_data, m_keep, m_last hold values.
REQ-022 Beat transfer and completion in the same cycle SHALL load the new beat with m_valid remaining 1 (back-to-back, full throughput: one beat per RATIO cycles).
REQ-023 While m_valid && !m_ready: m_data, m_keep, m_last SHALL stay stable and s_ready = 0; no word lost or overwritten.
REQ-024 Partial assembly (cnt > 0) SHALL persist indefinitely while s_valid = 0; no timeout flush.
REQ-025 s_last on lane 0 SHALL emit a beat with m_keep = 0b0001 (single-word packet).
REQ-026 beat_count SHALL increment by 1 on each beat transfer, modulo 2^16.
REQ-027 s_data SHALL be ignored when s_valid = 0 or s_ready = 0.

Reset
REQ-028 While rst = 1: m_valid=0, m_data=0, m_keep=0, m_last=0, beat_count=0, cnt=0, assembly register=0, s_ready=0.
REQ-029 Assertion of rst mid-packet SHALL discard the partial assembly and any pending beat immediately (asynchronously).
REQ-030 First word after rst deasserts SHALL land in lane 0.

Verification (WORD_WIDTH=8, RATIO=4)
REQ-031 Words 0x11,0x22,0x33,0x44 on consecutive cycles, m_ready=1 -> one cycle after 0x44: m_valid=1, m_data=0x44332211, m_keep=0xF, m_last=0, beat_count=1 the cycle after.
REQ-032 Words 0xA1,0xA2 with s_last on 0xA2 -> m_data=0x0000A2A1, m_keep=0x3, m_last=1; next word lands in lane 0.
REQ-033 Complete beat with m_ready=0 for 5 cycles -> s_ready=0, m_data stable 5 cycles; m_ready=1 -> beat transfers, s_ready=1 same cycle.
REQ-034 12 words streamed with m_ready=1 continuously -> 3 beats, no stall cycles on s_ready, beat_count=3.
REQ-035 rst pulsed after 2 words of a beat -> all outputs 0; subsequent 4 words 0x01..0x04 -> m_data=0x04030201, m_keep=0xF.
REQ-036 beat_count preloaded by 65535 beats -> next beat transfer wraps it to 0x0000.

Source files
------------

// File: rtl/word_packer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : word_packer_if
// Purpose  : Upstream word stream and downstream packed-beat stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface word_packer_if #(
    parameter int WORD_WIDTH = 8,
    parameter int RATIO      = 4
);
    logic                        s_valid;
    logic                        s_ready;
    logic [WORD_WIDTH-1:0]       s_data;
    logic                        s_last;
    logic                        m_valid;
    logic                        m_ready;
    logic [WORD_WIDTH*RATIO-1:0] m_data;
    logic [RATIO-1:0]            m_keep;
    logic                        m_last;

    // The packer itself: consumes words, produces beats.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );

    // The environment around the packer: word source and beat sink.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );
endinterface
`default_nettype wire

// File: rtl/word_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : word_packer
// Purpose  : Packs RATIO narrow words into one wide beat; s_last flushes early.
// Revision : 1.0 - initial release
// ============================================================================
module word_packer #(
    parameter int WORD_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    word_packer_if.slave bus,
    output logic [15:0]  beat_count
);
    localparam int c_cnt_w  = $clog2(RATIO);
    localparam int c_beat_w = WORD_WIDTH * RATIO;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(RATIO - 1);

    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [c_beat_w-1:0] asm_q, asm_d;
    logic                m_valid_q, m_valid_d;
    logic [c_beat_w-1:0] m_data_q, m_data_d;
    logic [RATIO-1:0]    m_keep_q, m_keep_d;
    logic                m_last_q, m_last_d;
    logic [15:0]         beat_count_q, beat_count_d;

    logic                w_s_ready;
    logic                w_word_xfer;
    logic                w_beat_xfer;
    logic                w_complete;
    logic [c_beat_w-1:0] w_fill;
    logic [RATIO-1:0]    w_keep_fill;

    always_comb begin
        w_s_ready   = !rst && (!m_valid_q || bus.m_ready);
        w_word_xfer = bus.s_valid && w_s_ready;
        w_beat_xfer = m_valid_q && bus.m_ready;
        w_complete  = w_word_xfer && (bus.s_last || (cnt_q == c_cnt_max));

        // Lanes above cnt are always zero in the assembly register, so the
        // merged image is directly usable as the outgoing beat.
        w_fill      = asm_q;
        w_keep_fill = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == c_cnt_w'(i)) begin
                w_fill[i*WORD_WIDTH +: WORD_WIDTH] = bus.s_data;
            end
            w_keep_fill[i] = (c_cnt_w'(i) <= cnt_q);
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        beat_count_d = beat_count_q + 16'(w_beat_xfer);

        if (w_beat_xfer) begin
            m_valid_d = 1'b0;
        end

        // Completion can only occur when the output slot is free or draining,
        // so it safely overrides the drop of m_valid above.
        if (w_complete) begin
            m_valid_d = 1'b1;
            m_data_d  = w_fill;
            m_keep_d  = w_keep_fill;
            m_last_d  = bus.s_last;
            cnt_d     = '0;
            asm_d     = '0;
        end else if (w_word_xfer) begin
            asm_d = w_fill;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            beat_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_keep  = m_keep_q;
    assign bus.m_last  = m_last_q;
    assign beat_count  = beat_count_q;
endmodule
`default_nettype wire

// File: tb/tb_word_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_word_packer
// Purpose  : Self-checking bench for word_packer (WORD_WIDTH=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_packer;
    localparam int W = 8;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] beat_count;

    always #5 clk = ~clk;

    word_packer_if #(.WORD_WIDTH(W), .RATIO(R)) bif ();

    word_packer #(.WORD_WIDTH(W), .RATIO(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .beat_count (beat_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    int          n_beats = 0;
    logic [7:0]  cur_q[$];
    beat_t       exp_q[$];
    beat_t       mon_b;
    beat_t       stall_b;
    logic        stall_prev = 1'b0;
    bit          rnd_done;

    // Reference model: words gathered at each handshake; a beat is due when
    // RATIO words are collected or a word carries s_last.
    always @(negedge clk) begin
        if (rst) begin
            cur_q.delete();
            exp_q.delete();
            n_beats    = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (bif.m_valid !== 1'b1 || {bif.m_data, bif.m_keep, bif.m_last} !== stall_b) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, want valid=1 beat=%h",
                             bif.m_valid, {bif.m_data, bif.m_keep, bif.m_last}, stall_b);
                end
            end
            stall_prev = (bif.m_valid === 1'b1) && (bif.m_ready === 1'b0);
            stall_b    = {bif.m_data, bif.m_keep, bif.m_last};
            if (bif.m_valid === 1'b1 && bif.m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h keep=%h, want no beat",
                             bif.m_data, bif.m_keep);
                end else begin
                    mon_b = exp_q.pop_front();
                    if ({bif.m_data, bif.m_keep, bif.m_last} !== mon_b) begin
                        errors++;
                        $display("FAIL beat_content: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                                 bif.m_data, bif.m_keep, bif.m_last, mon_b.data, mon_b.keep, mon_b.last);
                    end
                end
            end
            if (bif.s_valid === 1'b1 && bif.s_ready === 1'b1) begin
                cur_q.push_back(bif.s_data);
                if (cur_q.size() == R || bif.s_last === 1'b1) begin
                    mon_b.data = '0;
                    foreach (cur_q[i]) mon_b.data |= 32'(cur_q[i]) << (8 * i);
                    mon_b.keep = 4'((1 << cur_q.size()) - 1);
                    mon_b.last = bif.s_last;
                    exp_q.push_back(mon_b);
                    n_beats++;
                    cur_q.delete();
                end
            end
        end
    end

    // Present one word and hold it until accepted; returns at posedge+1.
    task automatic send_word(input logic [7:0] d, input logic l, output int waits);
        bif.s_valid = 1'b1;
        bif.s_data  = d;
        bif.s_last  = l;
        waits = 0;
        @(negedge clk);
        while (bif.s_ready !== 1'b1 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=%b, want 1 within 100 cycles", bif.s_ready);
        end
        @(posedge clk); #1;
        bif.s_valid = 1'b0;
        bif.s_data  = 8'($urandom);
        bif.s_last  = 1'($urandom);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        bif.s_last  = 1'b0;
        bif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bif.m_valid, bif.m_data, bif.m_keep, bif.m_last, beat_count, bif.s_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h keep=%h last=%b cnt=%h s_ready=%b, want all 0",
                     bif.m_valid, bif.m_data, bif.m_keep, bif.m_last, beat_count, bif.s_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, want 1", bif.s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_beat();
        int w;
        bif.m_ready = 1'b1;
        send_word(8'h11, 1'b0, w);
        send_word(8'h22, 1'b0, w);
        send_word(8'h33, 1'b0, w);
        send_word(8'h44, 1'b0, w);
        @(negedge clk);
        checks++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== 32'h44332211 || bif.m_keep !== 4'hF ||
            bif.m_last !== 1'b0 || beat_count !== 16'd0) begin
            errors++;
            $display("FAIL full_beat: got v=%b data=%h keep=%h last=%b cnt=%0d, want v=1 data=44332211 keep=f last=0 cnt=0",
                     bif.m_valid, bif.m_data, bif.m_keep, bif.m_last, beat_count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_count !== 16'd1 || bif.m_valid !== 1'b0 || bif.m_data !== 32'h44332211) begin
            errors++;
            $display("FAIL full_beat_after: got cnt=%0d v=%b data=%h, want cnt=1 v=0 data=44332211",
                     beat_count, bif.m_valid, bif.m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_last_flush();
        int w;
        send_word(8'hA1, 1'b0, w);
        send_word(8'hA2, 1'b1, w);
        @(negedge clk);
        checks++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== 32'h0000A2A1 || bif.m_keep !== 4'h3 || bif.m_last !== 1'b1) begin
            errors++;
            $display("FAIL last_flush: got v=%b data=%h keep=%h last=%b, want v=1 data=0000a2a1 keep=3 last=1",
                     bif.m_valid, bif.m_data, bif.m_keep, bif.m_last);
        end
        @(posedge clk); #1;
        send_word(8'h55, 1'b1, w);
        @(negedge clk);
        checks++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== 32'h00000055 || bif.m_keep !== 4'h1 || bif.m_last !== 1'b1) begin
            errors++;
            $display("FAIL single_word: got v=%b data=%h keep=%h last=%b, want v=1 data=00000055 keep=1 last=1",
                     bif.m_valid, bif.m_data, bif.m_keep, bif.m_last);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_count !== 16'd3) begin
            errors++;
            $display("FAIL last_count: got %0d, want 3", beat_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] exp_d;
        logic [7:0]  d;
        exp_d = '0;
        bif.m_ready = 1'b0;
        for (int i = 0; i < R; i++) begin
            d = 8'($urandom);
            exp_d |= 32'(d) << (8 * i);
            send_word(d, 1'b0, w);
        end
        // A waiting word must not be taken while the beat is stuck.
        bif.s_valid = 1'b1;
        bif.s_data  = 8'h5A;
        bif.s_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bif.s_ready !== 1'b0 || bif.m_valid !== 1'b1 || bif.m_data !== exp_d) begin
                errors++;
                $display("FAIL backpressure: got s_ready=%b v=%b data=%h, want s_ready=0 v=1 data=%h",
                         bif.s_ready, bif.m_valid, bif.m_data, exp_d);
            end
            @(posedge clk); #1;
        end
        bif.m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: got s_ready=%b, want 1", bif.s_ready);
        end
        @(posedge clk); #1;
        bif.s_valid = 1'b0;
        bif.s_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== 32'h0000005A || bif.m_keep !== 4'h1) begin
            errors++;
            $display("FAIL back_to_back_load: got v=%b data=%h keep=%h, want v=1 data=0000005a keep=1",
                     bif.m_valid, bif.m_data, bif.m_keep);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int w;
        int stalls;
        int base;
        base   = n_beats;
        stalls = 0;
        bif.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_word(8'($urandom), 1'b0, w);
            stalls += w;
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL stream_stalls: got %0d stall cycles, want 0", stalls);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_count !== 16'(base + 3)) begin
            errors++;
            $display("FAIL stream_count: got %0d, want %0d", beat_count, base + 3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w;
        bif.m_ready = 1'b0;
        for (int i = 0; i < R; i++) send_word(8'($urandom), 1'b0, w);
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({bif.m_valid, bif.m_data, bif.m_keep, bif.m_last, beat_count, bif.s_ready} !== '0) begin
                errors++;
                $display("FAIL reset_mid_%0d: got v=%b data=%h keep=%h last=%b cnt=%h s_ready=%b, want all 0",
                         pass, bif.m_valid, bif.m_data, bif.m_keep, bif.m_last, beat_count, bif.s_ready);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            bif.m_ready = 1'b1;
            if (pass == 0) begin
                send_word(8'hE1, 1'b0, w);
                send_word(8'hE2, 1'b0, w);
            end
        end
        send_word(8'h01, 1'b0, w);
        send_word(8'h02, 1'b0, w);
        send_word(8'h03, 1'b0, w);
        send_word(8'h04, 1'b0, w);
        @(negedge clk);
        checks++;
        if (bif.m_valid !== 1'b1 || bif.m_data !== 32'h04030201 || bif.m_keep !== 4'hF) begin
            errors++;
            $display("FAIL reset_then_beat: got v=%b data=%h keep=%h, want v=1 data=04030201 keep=f",
                     bif.m_valid, bif.m_data, bif.m_keep);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int w;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send_word(8'($urandom), 1'($urandom_range(0, 4) == 0), w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bif.m_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bif.m_ready = 1'b1;
        send_word(8'($urandom), 1'b1, w);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || beat_count !== 16'(n_beats)) begin
            errors++;
            $display("FAIL random_drain: got pending=%0d cnt=%0d, want pending=0 cnt=%0d",
                     exp_q.size(), beat_count, n_beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_count_wrap();
        int w;
        int m;
        m = 65535 - n_beats;
        bif.m_ready = 1'b1;
        bif.s_valid = 1'b1;
        bif.s_last  = 1'b1;
        for (int i = 0; i < m; i++) begin
            bif.s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        bif.s_valid = 1'b0;
        bif.s_last  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_max: got %h, want ffff", beat_count);
        end
        @(posedge clk); #1;
        send_word(8'h77, 1'b1, w);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (beat_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap: got %h, want 0000", beat_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, want completion before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_beat();
        test_last_flush();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_random();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
